ram_arbiter: RTL and testbench

Round-robin arbiter and sequencer for the single-port synchronous-write / asynchronous-read RAM (`ram`, 2**N × M). It shares the RAM between R requesters and grants exactly one access per cycle. It supports locked bursts with a bounded length and returns read data registered, with a one-hot valid. It sits between the requester blocks and the RAM instance and drives all RAM inputs.

---
 rtl/ram_arbiter.sv | 169 ++++++++++++++++
 tb/tb_ram_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Round-robin arbiter and sequencer in front of a single-port RAM with
// synchronous write and asynchronous read. Grants exactly one requester per
// cycle, supports locked bursts bounded to MAXB consecutive grants, and
// returns read data one cycle after the grant with a one-hot valid.
//
// Optional feature macro: RAM_ARB_FIXED_PRIO_EN
//   defined   -> idle arbitration is fixed priority (lowest index wins) and
//                the round-robin pointer stays at 0
//   undefined -> round-robin arbitration (default)
//
// Ports
//   clk       clock, all state on the rising edge
//   rst       synchronous active-high reset
//   req       per-requester request, held until granted
//   lock      with req, keep ownership for following cycles
//   we_in     per-requester write enable (1 write, 0 read)
//   adr_in    packed addresses, requester i at [i*N +: N]
//   din_in    packed write data, requester i at [i*M +: M]
//   gnt       one-hot combinational grant
//   rvalid    one-hot read-data-valid pulse
//   rdata     registered read data
//   ram_we    RAM write enable
//   ram_adr   RAM address
//   ram_din   RAM write data
//   ram_dout  RAM asynchronous read data
module ram_arbiter #(
  parameter int N    = 6,
  parameter int M    = 32,
  parameter int R    = 4,
  parameter int MAXB = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [R-1:0]   req,
  input  logic [R-1:0]   lock,
  input  logic [R-1:0]   we_in,
  input  logic [R*N-1:0] adr_in,
  input  logic [R*M-1:0] din_in,
  output logic [R-1:0]   gnt,
  output logic [R-1:0]   rvalid,
  output logic [M-1:0]   rdata,
  output logic           ram_we,
  output logic [N-1:0]   ram_adr,
  output logic [M-1:0]   ram_din,
  input  logic [M-1:0]   ram_dout
);

  localparam int PW = (R > 1) ? $clog2(R) : 1;
  localparam int CW = $clog2(MAXB + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

`ifdef RAM_ARB_FIXED_PRIO_EN
  localparam bit FIXED_PRIO = 1'b1;
`else
  localparam bit FIXED_PRIO = 1'b0;
`endif

  logic [0:0]    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] owner_q, owner_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [M-1:0]  rdata_q, rdata_d;
  logic [R-1:0]  rvalid_q, rvalid_d;

  logic [PW-1:0] release_ptr;
  logic [PW-1:0] arb_ptr;
  logic [PW-1:0] win_idx;
  logic          win_found;
  logic          grant;
  logic [PW-1:0] gnt_idx;
  logic          is_read;

  function automatic logic [PW-1:0] inc_mod(input logic [PW-1:0] p);
    return (int'(p) == R - 1) ? '0 : p + 1'b1;
  endfunction

  // Pointer used when a burst ends, and the start point of the search. When
  // the owner drops req mid-burst the same cycle is arbitrated from the
  // post-burst pointer, so no bubble is inserted.
  assign release_ptr = FIXED_PRIO ? '0 : inc_mod(owner_q);
  assign arb_ptr     = FIXED_PRIO ? '0 :
                       ((state_q == ST_BURST) ? release_ptr : ptr_q);

  // First active request at or after arb_ptr, wrapping modulo R.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < R; k++) begin
      if (!win_found && req[(int'(arb_ptr) + k) % R]) begin
        win_found = 1'b1;
        win_idx   = PW'((int'(arb_ptr) + k) % R);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    bcnt_d  = bcnt_q;
    grant   = 1'b0;
    gnt_idx = '0;
    if (rst) begin
      grant = 1'b0;
    end else if (state_q == ST_BURST && req[owner_q]) begin
      grant   = 1'b1;
      gnt_idx = owner_q;
      bcnt_d  = bcnt_q + 1'b1;
      if (!lock[owner_q] || (int'(bcnt_q) + 1 >= MAXB)) begin
        state_d = ST_IDLE;
        ptr_d   = release_ptr;
      end
    end else begin
      if (state_q == ST_BURST) begin
        state_d = ST_IDLE;
        ptr_d   = release_ptr;
      end
      if (win_found) begin
        grant   = 1'b1;
        gnt_idx = win_idx;
        if (lock[win_idx]) begin
          state_d = ST_BURST;
          owner_d = win_idx;
          bcnt_d  = CW'(1);
        end else if (!FIXED_PRIO) begin
          ptr_d = inc_mod(win_idx);
        end
      end
    end
  end

  for (genvar gi = 0; gi < R; gi++) begin : g_gnt
    assign gnt[gi] = grant && (gnt_idx == PW'(gi));
  end

  // With no grant gnt_idx is 0, so the RAM sees requester 0's bus.
  assign ram_adr = adr_in[int'(gnt_idx)*N +: N];
  assign ram_din = din_in[int'(gnt_idx)*M +: M];
  assign ram_we  = grant && we_in[gnt_idx];
  assign is_read = grant && !we_in[gnt_idx];

  assign rvalid_d = is_read ? gnt : '0;
  assign rdata_d  = is_read ? ram_dout : rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      owner_q  <= '0;
      bcnt_q   <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      bcnt_q   <= bcnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Testbench for ram_arbiter: directed vector table, a write/read sequence,
// and randomized traffic checked against a cycle-level reference model.
// Honours RAM_ARB_FIXED_PRIO_EN in both its table and its model.
module tb_ram_arbiter;
  localparam int N    = 6;
  localparam int M    = 32;
  localparam int R    = 4;
  localparam int MAXB = 4;

  logic           clk;
  logic           rst;
  logic [R-1:0]   req, lock, we_in;
  logic [R*N-1:0] adr_in;
  logic [R*M-1:0] din_in;
  logic [R-1:0]   gnt, rvalid;
  logic [M-1:0]   rdata;
  logic           ram_we;
  logic [N-1:0]   ram_adr;
  logic [M-1:0]   ram_din;
  logic [M-1:0]   ram_dout;

  int checks   = 0;
  int failures = 0;

  ram_arbiter #(.N(N), .M(M), .R(R), .MAXB(MAXB)) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we_in(we_in),
    .adr_in(adr_in), .din_in(din_in), .gnt(gnt), .rvalid(rvalid),
    .rdata(rdata), .ram_we(ram_we), .ram_adr(ram_adr), .ram_din(ram_din),
    .ram_dout(ram_dout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Environment RAM: synchronous write, asynchronous read.
  logic [M-1:0] ram_mem [2**N];
  initial for (int i = 0; i < 2**N; i++) ram_mem[i] = '0;
  always @(posedge clk) if (ram_we) ram_mem[ram_adr] <= ram_din;
  assign ram_dout = ram_mem[ram_adr];

  // Reference model: owner/grant-count bookkeeping plus an expected memory.
  logic [M-1:0] exp_mem [2**N];
  int           m_ptr, m_owner, m_cnt;
  bit           m_burst, m_valid;
  logic [R-1:0] m_rvalid;
  logic [M-1:0] m_rdata;
  logic [R-1:0] s_gnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int next_ptr(input int p);
`ifdef RAM_ARB_FIXED_PRIO_EN
    return 0 + 0 * p;
`else
    return (p + 1) % R;
`endif
  endfunction

  function automatic int pick();
    int start;
    if (rst) return -1;
    if (m_burst && req[m_owner]) return m_owner;
`ifdef RAM_ARB_FIXED_PRIO_EN
    start = 0;
`else
    start = m_burst ? (m_owner + 1) % R : m_ptr;
`endif
    for (int k = 0; k < R; k++)
      if (req[(start + k) % R]) return (start + k) % R;
    return -1;
  endfunction

  // One clock cycle: check at the falling edge, advance the model at the
  // rising edge, return 1 time unit later so the caller can drive inputs.
  task automatic step();
    int idx;
    logic [R-1:0] eg;
    logic [N-1:0] eadr;
    @(negedge clk);
    idx  = pick();
    eg   = (idx >= 0) ? R'(1 << idx) : '0;
    eadr = adr_in[((idx >= 0) ? idx : 0)*N +: N];
    s_gnt = gnt;
    chk("gnt", gnt, eg);
    chk("ram_we", ram_we, (idx >= 0) ? we_in[idx] : 1'b0);
    if (!rst) begin
      chk("ram_adr", ram_adr, eadr);
      chk("ram_din", ram_din, din_in[((idx >= 0) ? idx : 0)*M +: M]);
    end
    if (m_valid) begin
      chk("rvalid", rvalid, m_rvalid);
      chk("rdata", rdata, m_rdata);
    end
    if (idx >= 0) $display("txn t=%0t gnt=%b we=%b adr=%h", $time, gnt, ram_we, ram_adr);
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_owner = 0; m_cnt = 0; m_burst = 0;
      m_rvalid = '0; m_rdata = '0; m_valid = 1;
    end else begin
      if (idx >= 0 && !we_in[idx]) begin
        m_rvalid = eg;
        m_rdata  = exp_mem[eadr];
      end else begin
        m_rvalid = '0;
      end
      if (idx >= 0 && we_in[idx]) exp_mem[eadr] = din_in[idx*M +: M];
      if (m_burst && req[m_owner]) begin
        m_cnt++;
        if (!lock[m_owner] || m_cnt >= MAXB) begin
          m_burst = 0;
          m_ptr   = next_ptr(m_owner);
        end
      end else begin
        if (m_burst) begin
          m_burst = 0;
          m_ptr   = next_ptr(m_owner);
        end
        if (idx >= 0) begin
          if (lock[idx]) begin
            m_burst = 1; m_owner = idx; m_cnt = 1;
          end else begin
            m_ptr = next_ptr(idx);
          end
        end
      end
    end
    #1;
  endtask

  typedef struct {
    logic         rst;
    logic [R-1:0] req;
    logic [R-1:0] lock;
    logic [R-1:0] we;
    logic [N-1:0] adr;
    logic [M-1:0] din;
    logic [R-1:0] exp_gnt;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [R-1:0] q, input logic [R-1:0] l,
                              input logic [R-1:0] w, input int a, input logic [R-1:0] g);
    vec_t v;
    v.rst = r; v.req = q; v.lock = l; v.we = w;
    v.adr = N'(a); v.din = 32'h1000_0000 + M'(a); v.exp_gnt = g;
    return v;
  endfunction

  initial begin
    logic [R-1:0] rr_seq [4];
    rr_seq[0] = 4'b0001; rr_seq[1] = 4'b0010; rr_seq[2] = 4'b0100; rr_seq[3] = 4'b1000;
    for (int i = 0; i < 2**N; i++) exp_mem[i] = '0;
    m_valid = 0; m_ptr = 0; m_owner = 0; m_cnt = 0; m_burst = 0;
    m_rvalid = '0; m_rdata = '0;
    rst = 1'b1; req = '0; lock = '0; we_in = '0; adr_in = '0; din_in = '0;

    // Reset with all requests pending: no grant, no write.
    tbl.push_back(mk(1, 4'b1111, 4'b0000, 4'b1111, 0, 4'b0000));
    tbl.push_back(mk(1, 4'b1111, 4'b0000, 4'b1111, 1, 4'b0000));
`ifdef RAM_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 6; k++) tbl.push_back(mk(0, 4'b0110, 4'b0000, 4'b0000, k, 4'b0010));
`else
    for (int k = 0; k < 8; k++) tbl.push_back(mk(0, 4'b1111, 4'b0000, 4'b0000, k, rr_seq[k % 4]));
    // Requester 1 locks, requester 3 waits: 4 grants, 1 grant, 4 grants, 1 grant.
    for (int k = 0; k < 10; k++)
      tbl.push_back(mk(0, 4'b1010, 4'b0010, 4'b0000, 8 + k,
                       (k == 4 || k == 9) ? 4'b1000 : 4'b0010));
`endif
    // Burst early end: requester 2 granted immediately after requester 0 drops.
    tbl.push_back(mk(0, 4'b0101, 4'b0001, 4'b0000, 20, 4'b0001));
    tbl.push_back(mk(0, 4'b0101, 4'b0001, 4'b0000, 21, 4'b0001));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, 22, 4'b0100));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b1111, 23, 4'b0000));
    // Reset mid-burst: afterwards requester 0 wins from pointer 0.
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 4'b0000, 24, 4'b0010));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 4'b0000, 25, 4'b0010));
    tbl.push_back(mk(1, 4'b0011, 4'b0010, 4'b0000, 26, 4'b0000));
    tbl.push_back(mk(0, 4'b0011, 4'b0000, 4'b0000, 27, 4'b0001));

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; req = tbl[i].req; lock = tbl[i].lock; we_in = tbl[i].we;
      adr_in = {R{tbl[i].adr}}; din_in = {R{tbl[i].din}};
      step();
      chk("tbl_gnt", s_gnt, tbl[i].exp_gnt);
      $display("vec %0d rst=%b req=%b lock=%b gnt=%b", i, tbl[i].rst, tbl[i].req, tbl[i].lock, s_gnt);
      if (i == 1) begin
        chk("rst_rvalid", rvalid, '0);
        chk("rst_rdata", rdata, '0);
      end
    end

    // Write by requester 2 then read of the same address by requester 1.
    rst = 0; lock = '0; adr_in = '0; din_in = '0;
    req = 4'b0100; we_in = 4'b0100;
    adr_in[2*N +: N] = 6'h2A; din_in[2*M +: M] = 32'hDEADBEEF;
    step();
    req = 4'b0010; we_in = 4'b0000; adr_in[1*N +: N] = 6'h2A;
    step();
    chk("wr_rd_rvalid", rvalid, 4'b0010);
    chk("wr_rd_rdata", rdata, 32'hDEADBEEF);
    req = '0;
    step();
    chk("wr_rd_rvalid_pulse", rvalid, 4'b0000);

    // Randomized traffic against the model, with occasional resets.
    for (int c = 0; c < 600; c++) begin
      rst   = ($urandom_range(0, 63) == 0);
      req   = R'($urandom);
      lock  = R'($urandom) & R'($urandom);
      we_in = R'($urandom);
      for (int i = 0; i < R; i++) begin
        adr_in[i*N +: N] = N'($urandom_range(0, 7));
        din_in[i*M +: M] = M'($urandom);
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
